// File: rtl/exp2_pkg.sv
// Shared constants for the exp2_fixed_point datapath: widths and the
// fractional-power LUT m[k] = round(2^(k/16) * 32768) with slopes d[k] = m[k+1] - m[k].
// m[16] = 65536 is folded into d[15].
package exp2_pkg;

    localparam int LOG_W   = 12;
    localparam int INT_W   = 4;
    localparam int FRAC_W  = 8;
    localparam int MANT_W  = 16;
    localparam int OUT_W   = 16;
    localparam int KIDX_W  = 4;
    localparam int SUB_W   = 4;
    localparam int SLOPE_W = 12;

    // Q1.15 mantissa base value for segment k
    function automatic logic [MANT_W-1:0] m_entry(input logic [KIDX_W-1:0] k);
        logic [MANT_W-1:0] m;
        case (k)
            4'd0:    m = 16'd32768;
            4'd1:    m = 16'd34219;
            4'd2:    m = 16'd35734;
            4'd3:    m = 16'd37316;
            4'd4:    m = 16'd38968;
            4'd5:    m = 16'd40693;
            4'd6:    m = 16'd42495;
            4'd7:    m = 16'd44376;
            4'd8:    m = 16'd46341;
            4'd9:    m = 16'd48393;
            4'd10:   m = 16'd50535;
            4'd11:   m = 16'd52773;
            4'd12:   m = 16'd55109;
            4'd13:   m = 16'd57549;
            4'd14:   m = 16'd60097;
            4'd15:   m = 16'd62757;
            default: m = 16'd32768;
        endcase
        return m;
    endfunction

    // Slope to the next segment, d[k] = m[k+1] - m[k]
    function automatic logic [SLOPE_W-1:0] d_entry(input logic [KIDX_W-1:0] k);
        logic [SLOPE_W-1:0] d;
        case (k)
            4'd0:    d = 12'd1451;
            4'd1:    d = 12'd1515;
            4'd2:    d = 12'd1582;
            4'd3:    d = 12'd1652;
            4'd4:    d = 12'd1725;
            4'd5:    d = 12'd1802;
            4'd6:    d = 12'd1881;
            4'd7:    d = 12'd1965;
            4'd8:    d = 12'd2052;
            4'd9:    d = 12'd2142;
            4'd10:   d = 12'd2238;
            4'd11:   d = 12'd2336;
            4'd12:   d = 12'd2440;
            4'd13:   d = 12'd2548;
            4'd14:   d = 12'd2660;
            4'd15:   d = 12'd2779;
            default: d = 12'd1451;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/exp2_frac_lut.sv
// Combinational fractional-power lookup: base mantissa and slope for segment k.
module exp2_frac_lut
    import exp2_pkg::*;
(
    input  logic [KIDX_W-1:0]  k,
    output logic [MANT_W-1:0]  m,
    output logic [SLOPE_W-1:0] d
);

    // Table lookup for base value and interpolation slope
    always_comb begin
        m = m_entry(k);
        d = d_entry(k);
    end

endmodule

// File: rtl/exp2_fixed_point.sv
// exp2_fixed_point: 3-stage pipelined 2^x for ufix12_En8 input, uint16 output.
// S1 registers LUT base/slope, S2 the interpolated mantissa, S3 the shifted result.
// Optional macro EXP2_ROUND_EN: round-to-nearest with saturation in S3
// (default build truncates).
module exp2_fixed_point
    import exp2_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LOG_W-1:0] i_LOG,
    input  logic             i_VALID,
    output logic             o_READY,
    output logic [OUT_W-1:0] o_EXP,
    output logic             o_VALID,
    input  logic             i_READY
);

    logic               advance_s;
    logic [MANT_W-1:0]  lut_m_s;
    logic [SLOPE_W-1:0] lut_d_s;

    logic               s1_valid_r;
    logic [INT_W-1:0]   s1_int_r;
    logic [SUB_W-1:0]   s1_frac_r;
    logic [MANT_W-1:0]  s1_m_r;
    logic [SLOPE_W-1:0] s1_d_r;

    logic [MANT_W-1:0]  prod_s;
    logic [MANT_W-1:0]  prod_shr_s;
    logic [MANT_W-1:0]  mant_s;

    logic               s2_valid_r;
    logic [INT_W-1:0]   s2_int_r;
    logic [MANT_W-1:0]  s2_mant_r;

    logic [INT_W-1:0]   shift_s;
    logic [OUT_W-1:0]   exp_next_s;

    // Whole pipeline moves together unless the output is held by downstream
    assign advance_s = ~o_VALID | i_READY;
    assign o_READY   = advance_s;

    exp2_frac_lut u_frac_lut (
        .k (i_LOG[FRAC_W-1:SUB_W]),
        .m (lut_m_s),
        .d (lut_d_s)
    );

    // S1: capture integer part, low fraction nibble and LUT outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_int_r   <= 4'd0;
            s1_frac_r  <= 4'd0;
            s1_m_r     <= 16'd0;
            s1_d_r     <= 12'd0;
        end else if (advance_s) begin
            s1_valid_r <= i_VALID;
            s1_int_r   <= i_LOG[LOG_W-1:FRAC_W];
            s1_frac_r  <= i_LOG[SUB_W-1:0];
            s1_m_r     <= lut_m_s;
            s1_d_r     <= lut_d_s;
        end
    end

    // Linear interpolation; full 16-bit product before the shift, sum cannot exceed 65362
    always_comb begin
        prod_s     = {4'd0, s1_d_r} * {12'd0, s1_frac_r};
        prod_shr_s = prod_s >> 4;
        mant_s     = s1_m_r + prod_shr_s;
    end

    // S2: capture interpolated mantissa
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_int_r   <= 4'd0;
            s2_mant_r  <= 16'd0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_int_r   <= s1_int_r;
            s2_mant_r  <= mant_s;
        end
    end

    assign shift_s = 4'd15 - s2_int_r;

`ifdef EXP2_ROUND_EN
    logic [MANT_W:0] half_s;
    logic [MANT_W:0] rsum_s;
    logic [MANT_W:0] rshift_s;

    // Round to nearest by adding half of the discarded LSB weight, then saturate
    always_comb begin
        if (shift_s != 4'd0) begin
            half_s = 17'd1 << (shift_s - 4'd1);
        end else begin
            half_s = 17'd0;
        end
        rsum_s   = {1'b0, s2_mant_r} + half_s;
        rshift_s = rsum_s >> shift_s;
        if (rshift_s[MANT_W]) begin
            exp_next_s = 16'hFFFF;
        end else begin
            exp_next_s = rshift_s[OUT_W-1:0];
        end
    end
`else
    // Truncating scale by the integer exponent
    always_comb begin
        exp_next_s = s2_mant_r >> shift_s;
    end
`endif

    // S3: registered result; bubbles clear the data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_VALID <= 1'b0;
            o_EXP   <= 16'd0;
        end else if (advance_s) begin
            o_VALID <= s2_valid_r;
            o_EXP   <= s2_valid_r ? exp_next_s : 16'd0;
        end
    end

endmodule
